// File: rtl/uart_pkg.sv
// uart_pkg: default UART constants shared by the TX and RX tops, plus the RX FSM state type
package uart_pkg;
  localparam int DBITS_DEF    = 8;
  localparam int SB_TICK_DEF  = 16;
  localparam int BR_LIMIT_DEF = 651;
  localparam int BR_BITS_DEF  = 10;
  localparam int FIFO_EXP_DEF = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO of 2**FIFO_EXP entries with registered empty/full flags
//   clk_100MHz, reset_n : clock, async active-low reset
//   wr, w_data          : push (dropped when full unless rd is also high)
//   rd                  : pop the head (ignored when empty)
//   r_data              : current head, valid while empty=0
//   empty, full         : occupancy flags
module uart_rx_fifo #(
  parameter int DBITS    = 8,
  parameter int FIFO_EXP = 2
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] w_data,
  output logic [DBITS-1:0] r_data,
  output logic             empty,
  output logic             full
);
  logic [DBITS-1:0]    mem [2**FIFO_EXP];
  logic [FIFO_EXP-1:0] w_ptr, r_ptr, w_nxt, r_nxt;
  logic                wr_en, rd_en;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign wr_en  = wr & (~full | rd);
  assign rd_en  = rd & ~empty;
  assign w_nxt  = w_ptr + FIFO_EXP'(1);
  assign r_nxt  = r_ptr + FIFO_EXP'(1);
  assign r_data = mem[r_ptr];
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      mem   <= '{default: '0};
      w_ptr <= '0;
      r_ptr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[w_ptr] <= w_data;
        w_ptr      <= w_nxt;
      end
      if (rd_en) r_ptr <= r_nxt;
      if (wr_en & ~rd_en) begin
        empty <= 1'b0;
        full  <= w_nxt == r_ptr;
      end else if (rd_en & ~wr_en) begin
        full  <= 1'b0;
        empty <= r_nxt == w_ptr;
      end
    end
endmodule

// File: rtl/uart_rx_top.sv
// uart_rx_top: 16x-oversampling 8N1 UART receiver feeding a show-ahead byte FIFO
//   clk_100MHz, reset_n : clock, async active-low reset
//   rx                  : asynchronous serial line, idle high
//   read_uart           : one-cycle pop strobe for the FIFO head
//   clear_err           : clears the sticky error flags
//   read_data           : FIFO head (valid while rx_empty=0)
//   rx_empty, rx_full   : FIFO occupancy
//   frame_err, overrun  : sticky bad-stop-bit and dropped-byte flags
module uart_rx_top import uart_pkg::*; #(
  parameter int DBITS    = DBITS_DEF,
  parameter int SB_TICK  = SB_TICK_DEF,
  parameter int BR_LIMIT = BR_LIMIT_DEF,
  parameter int BR_BITS  = BR_BITS_DEF,
  parameter int FIFO_EXP = FIFO_EXP_DEF
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             read_uart,
  input  logic             clear_err,
  output logic [DBITS-1:0] read_data,
  output logic             rx_empty,
  output logic             rx_full,
  output logic             frame_err,
  output logic             overrun
);
  localparam int NB = $clog2(DBITS);
  logic               rx_meta, rx_sync, tick, rx_done, wr, fe_set, ov_set;
  logic [BR_BITS-1:0] br_cnt;
  rx_state_t          state, state_nxt;
  logic [3:0]         s_reg, s_nxt;
  logic [NB-1:0]      n_reg, n_nxt;
  logic [DBITS-1:0]   b_reg, b_nxt;
  assign tick = br_cnt == BR_BITS'(BR_LIMIT - 1);
  // idle-high reset value keeps the FSM from seeing a false start edge after reset
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      br_cnt  <= '0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      br_cnt  <= tick ? '0 : br_cnt + BR_BITS'(1);
    end
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      s_reg <= '0;
      n_reg <= '0;
      b_reg <= '0;
    end else begin
      state <= state_nxt;
      s_reg <= s_nxt;
      n_reg <= n_nxt;
      b_reg <= b_nxt;
    end
  always_comb begin
    state_nxt = state;
    s_nxt     = s_reg;
    n_nxt     = n_reg;
    b_nxt     = b_reg;
    rx_done   = 1'b0;
    case (state)
      IDLE:
        if (!rx_sync) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      START:
        if (tick) begin
          if (s_reg == 4'd7) begin
            // a line already back high at mid start bit was a glitch
            state_nxt = rx_sync ? IDLE : DATA;
            s_nxt     = '0;
            n_nxt     = '0;
          end else s_nxt = s_reg + 4'd1;
        end
      DATA:
        if (tick) begin
          if (s_reg == 4'd15) begin
            s_nxt = '0;
            b_nxt = {rx_sync, b_reg[DBITS-1:1]};
            if (n_reg == NB'(DBITS - 1)) state_nxt = STOP;
            else n_nxt = n_reg + NB'(1);
          end else s_nxt = s_reg + 4'd1;
        end
      STOP:
        if (tick) begin
          if (s_reg == 4'(SB_TICK - 1)) begin
            state_nxt = IDLE;
            rx_done   = 1'b1;
          end else s_nxt = s_reg + 4'd1;
        end
      default: state_nxt = IDLE;
    endcase
  end
  assign wr     = rx_done & rx_sync;
  assign fe_set = rx_done & ~rx_sync;
  assign ov_set = wr & rx_full & ~read_uart;
  // an error event in the same cycle as clear_err keeps the flag set
  always_ff @(posedge clk_100MHz or negedge reset_n)
    if (!reset_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set | (frame_err & ~clear_err);
      overrun   <= ov_set | (overrun & ~clear_err);
    end
  uart_rx_fifo #(.DBITS(DBITS), .FIFO_EXP(FIFO_EXP)) u_fifo (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .wr        (wr),
    .rd        (read_uart),
    .w_data    (b_reg),
    .r_data    (read_data),
    .empty     (rx_empty),
    .full      (rx_full)
  );
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: table-driven and randomized checks of uart_rx_top against a byte-level queue model
module tb_uart_rx_top;
  localparam int BRL   = 4;
  localparam int BT    = BRL * 16;
  localparam int DEPTH = 4;
  logic       clk_100MHz = 1'b0;
  logic       reset_n = 1'b0, rx = 1'b1, read_uart = 1'b0, clear_err = 1'b0;
  logic [7:0] read_data;
  logic       rx_empty, rx_full, frame_err, overrun;
  int         errors = 0, checks = 0;
  logic [7:0] q[$];
  bit         m_fe = 1'b0, m_ov = 1'b0;
  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         clr;
    int         pops;
    bit         e, f, fe, ov;
    logic [7:0] hd;
  } row_t;
  row_t tbl[10];

  always #5 clk_100MHz = ~clk_100MHz;

  uart_rx_top #(.BR_LIMIT(BRL)) dut (
    .clk_100MHz(clk_100MHz),
    .reset_n   (reset_n),
    .rx        (rx),
    .read_uart (read_uart),
    .clear_err (clear_err),
    .read_data (read_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else m_ov = 1'b1;
  endtask

  // a bad stop bit is held low only past mid-bit so the receiver rejects the tail as a glitch
  task automatic send_frame(input logic [7:0] d, input bit stop);
    rx = 1'b0;
    wait_clk(BT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(BT);
    end
    if (stop) begin
      rx = 1'b1;
      wait_clk(BT);
    end else begin
      rx = 1'b0;
      wait_clk(BT / 2 + 16);
      rx = 1'b1;
      wait_clk(BT);
    end
    model_frame(d, stop);
  endtask

  task automatic pop();
    if (q.size() != 0) chk("pop_data", 32'(read_data), 32'(q[0]));
    read_uart = 1'b1;
    wait_clk(1);
    read_uart = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clr();
    clear_err = 1'b1;
    wait_clk(1);
    clear_err = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_empty"}, 32'(rx_empty), 32'(q.size() == 0));
    chk({nm, "_full"}, 32'(rx_full), 32'(q.size() == DEPTH));
    chk({nm, "_fe"}, 32'(frame_err), 32'(m_fe));
    chk({nm, "_ov"}, 32'(overrun), 32'(m_ov));
    if (q.size() != 0) chk({nm, "_head"}, 32'(read_data), 32'(q[0]));
  endtask

  initial begin
    tbl[0] = '{8'hAA, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
    tbl[1] = '{8'hCC, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA};
    tbl[2] = '{8'h01, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[3] = '{8'h02, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{8'h03, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[6] = '{8'h04, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[7] = '{8'h05, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
    tbl[8] = '{8'h66, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[9] = '{8'h77, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77};

    wait_clk(3);
    chk("rst_data", 32'(read_data), 32'h0);
    chk("rst_empty", 32'(rx_empty), 32'h1);
    chk("rst_full", 32'(rx_full), 32'h0);
    chk("rst_fe", 32'(frame_err), 32'h0);
    chk("rst_ov", 32'(overrun), 32'h0);
    reset_n = 1'b1;
    wait_clk(BT);

    // single 0xA5 frame with latency probes around the mid stop bit
    rx = 1'b0;
    wait_clk(BT);
    for (int i = 0; i < 8; i++) begin
      rx = 8'hA5 >> i;
      wait_clk(BT);
    end
    rx = 1'b1;
    wait_clk(16);
    chk("a5_early_empty", 32'(rx_empty), 32'h1);
    wait_clk(BT / 2);
    chk("a5_late_empty", 32'(rx_empty), 32'h0);
    chk("a5_data", 32'(read_data), 32'hA5);
    wait_clk(BT / 2 - 16);
    model_frame(8'hA5, 1'b1);
    pop();
    chk("a5_pop_empty", 32'(rx_empty), 32'h1);

    // quarter-bit start glitch, then a real frame to show recovery
    rx = 1'b0;
    wait_clk(BT / 4);
    rx = 1'b1;
    wait_clk(BT * 2);
    chk("glitch_empty", 32'(rx_empty), 32'h1);
    chk("glitch_fe", 32'(frame_err), 32'h0);
    send_frame(8'h5A, 1'b1);
    chk_model("recover");
    pop();

    // pop while empty is ignored
    pop();
    chk("empty_pop_empty", 32'(rx_empty), 32'h1);
    chk("empty_pop_full", 32'(rx_full), 32'h0);
    chk("empty_pop_ov", 32'(overrun), 32'h0);

    for (int r = 0; r < 10; r++) begin
      if (tbl[r].clr) clr();
      for (int p = 0; p < tbl[r].pops; p++) pop();
      send_frame(tbl[r].d, tbl[r].stop);
      chk($sformatf("tbl%0d_empty", r), 32'(rx_empty), 32'(tbl[r].e));
      chk($sformatf("tbl%0d_full", r), 32'(rx_full), 32'(tbl[r].f));
      chk($sformatf("tbl%0d_fe", r), 32'(frame_err), 32'(tbl[r].fe));
      chk($sformatf("tbl%0d_ov", r), 32'(overrun), 32'(tbl[r].ov));
      if (!tbl[r].e) chk($sformatf("tbl%0d_head", r), 32'(read_data), 32'(tbl[r].hd));
    end
    pop();
    chk("tbl_drain_empty", 32'(rx_empty), 32'h1);

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) clr();
      for (int p = $urandom_range(0, 2); p > 0; p--) pop();
      send_frame(8'($urandom), $urandom_range(0, 7) != 0);
      chk_model($sformatf("rnd%0d", r));
    end

    // reset in the middle of the data bits of 0x7E
    send_frame(8'h11, 1'b1);
    rx = 1'b0;
    wait_clk(BT);
    for (int i = 0; i < 3; i++) begin
      rx = 8'h7E >> i;
      wait_clk(BT);
    end
    reset_n = 1'b0;
    rx = 1'b1;
    wait_clk(2);
    chk("midrst_empty", 32'(rx_empty), 32'h1);
    chk("midrst_data", 32'(read_data), 32'h0);
    chk("midrst_fe", 32'(frame_err), 32'h0);
    q.delete();
    m_fe = 1'b0;
    m_ov = 1'b0;
    reset_n = 1'b1;
    wait_clk(BT * 2);
    send_frame(8'h42, 1'b1);
    chk_model("after_rst");
    chk("after_rst_head", 32'(read_data), 32'h42);
    pop();
    chk("after_rst_empty", 32'(rx_empty), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
